cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle controller that steps the CPU datapath through fetch, decode, execute, memory and writeback.
- Lets one single-port RAM serve both instruction fetch and load/store.
- Owns the PC and the retired-instruction counter.
- Consumes the decoded class flags produced from the latched instruction register; drives IR load, RAM request/handshake, register-file write enable and writeback select.

Parameters:
PC_W, 32, PC width in bits; word-addressed, wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
run  in  1  enable; checked only at instruction boundaries
dec_load  in  1  decoded RAM-load flag for instruction in IR
dec_store  in  1  decoded RAM-write flag
dec_jump  in  1  decoded jump flag
dec_imm  in  1  decoded immediate (sign-extension) flag
dec_alu  in  3  decoded ALU function
instr_zero  in  1  IR equals 32'h0 (NOP)
jump_offset  in  16  signed jump offset from IR[15:0]
mem_ready  in  1  RAM completes current request this cycle
mem_req  out  1  RAM request
mem_we  out  1  RAM write strobe (valid with mem_req)
mem_addr_sel  out  1  0 = PC, 1 = data address from decode
ir_load  out  1  IR captures RAM read data this cycle
reg_we  out  1  register-file write enable
wb_sel  out  1  0 = ALU result, 1 = RAM read data
pc  out  PC_W  current PC
retired  out  1  one-cycle pulse per completed instruction
instr_count  out  CNT_W  retired-instruction count, wraps
busy  out  1  state != IDLE
err  out  1  sticky illegal-instruction flag
state  out  3  current state encoding, for debug

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, instr_count=0, err=0. All strobes are 0: mem_req, mem_we, ir_load, reg_we, retired. mem_addr_sel=0, wb_sel=0.
- Reset at any cycle wins. Any pending RAM handshake is abandoned: mem_req is 0 the cycle after the reset edge.
- IDLE: if run && !err -> FETCH. Otherwise stay.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. Wait indefinitely for mem_ready. The cycle mem_ready=1: ir_load=1, -> DECODE. Zero-wait RAM gives a 1-cycle FETCH.
- DECODE (1 cycle): latch the class from the dec_* flags. Later flag changes are ignored until the next DECODE. Priority and legality:
  - instr_zero -> NOP: retire, pc=pc+1.
  - More than one of {dec_load, dec_store, dec_jump, dec_imm} set -> illegal: err=1, pc unchanged, no retire, -> IDLE.
  - dec_jump -> retire, pc=pc+1+sext(jump_offset), mod 2^PC_W.
  - dec_load or dec_store -> MEM.
  - dec_imm or dec_alu!=0 -> EXEC.
  - None set and dec_alu==0 with instr_zero=0 -> illegal (as above).
- EXEC (1 cycle) -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=latched store. Wait for mem_ready.
  - On ready, store: retire, pc=pc+1.
  - On ready, load: -> WB.
- WB (1 cycle): reg_we=1, wb_sel=latched load. Retire, pc=pc+1.
- Retire (same cycle as the last state):
  - retired=1, instr_count+=1 (wraps).
  - pc updated on that edge.
  - Next state = FETCH if run else IDLE.
  - run deassert mid-instruction completes the instruction first.
- Latencies with zero-wait RAM: NOP/jump 2 cycles; store 3; ALU/imm 4; load 4.
- mem_ready outside FETCH/MEM is ignored.
- mem_we is never 1 without mem_req.
- err clears only on rst. While err=1, run is ignored.
- pc+1 at all-ones wraps to 0. Negative offsets wrap the same way.

Decomposition:
- Package cpu_seq_pkg holds:
  - State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
  - Instruction-class constants: NOP, JUMP, LOAD, STORE, ALU, IMM, ILLEGAL.
  - PC increment constant.
- One natural sub-module, pc_unit: PC register plus next-PC adder with sign extension.
- FSM and counter stay in cpu_sequencer.

Test Plan:
- ALU instruction (dec_alu=3'b010), mem_ready tied 1, pc=0: FETCH, DECODE, EXEC, WB with reg_we=1 and wb_sel=0 in WB. retired at cycle 4, pc=1, instr_count=1.
- Load with mem_ready delayed 3 cycles in MEM: mem_req=1, mem_addr_sel=1, mem_we=0 held 3 cycles. WB has wb_sel=1. Retire at cycle 7, pc+1.
- Jump at pc=10 with jump_offset=16'hFFF0: pc becomes 32'hFFFFFFFB. Next FETCH drives mem_addr_sel=0.
- dec_load=1 and dec_jump=1 together: err=1, state IDLE, pc unchanged, instr_count unchanged. run=1 stays IDLE until rst.
- rst asserted while in MEM with mem_ready=0: the next cycle has mem_req=0, pc=RESET_PC, instr_count=0.
- run dropped during EXEC of an ALU instruction: WB still completes and retired=1, then IDLE. pc=0xFFFFFFFF NOP retire wraps pc to 0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, instruction classes, PC step.
// The classifier resolves decode-flag priority and legality in one place.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        JUMP    = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        ALU     = 3'd4,
        IMM     = 3'd5,
        ILLEGAL = 3'd6
    } cls_t;

    localparam int unsigned PC_INC = 1;

    // An all-zero word is a NOP even if the decoder raises stray flags for it.
    function automatic cls_t classify(
        input logic       ld,
        input logic       st,
        input logic       jp,
        input logic       im,
        input logic [2:0] alu,
        input logic       zero
    );
        if (zero)                            return NOP;
        if ($countones({ld, st, jp, im}) > 1) return ILLEGAL;
        if (jp)                              return JUMP;
        if (ld)                              return LOAD;
        if (st)                              return STORE;
        if (im)                              return IMM;
        if (alu != 3'd0)                     return ALU;
        return ILLEGAL;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// RAM request/handshake bundle between the sequencer (master) and the shared RAM port (slave).
// mem_ready completes whatever request is held that cycle; ir_load tells the IR to capture read data.
interface cpu_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic ir_load;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        output ir_load,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        input  ir_load,
        output mem_ready
    );
endinterface

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter with next-PC adder: pc+1, or pc+1+sext(offset) for jumps, wrapping mod 2^PC_W.
// Updates only on the advance strobe; no backpressure of its own.
module pc_unit
    import cpu_seq_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            jump,
    input  logic [15:0]     jump_offset,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_next;

    always_comb begin
        off_ext = '0;
        if (jump) begin
            off_ext = PC_W'($signed(jump_offset));
        end
        pc_next = pc + PC_W'(PC_INC) + off_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb controller sharing one RAM port; 2-4 cycles per instruction plus RAM waits.
// Stalls indefinitely in FETCH/MEM until mem_ready; run is sampled only at instruction boundaries.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  dec_load,
    input  logic                  dec_store,
    input  logic                  dec_jump,
    input  logic                  dec_imm,
    input  logic [2:0]            dec_alu,
    input  logic                  instr_zero,
    input  logic [15:0]           jump_offset,
    cpu_sequencer_if.master       mem,
    output logic                  reg_we,
    output logic                  wb_sel,
    output logic [PC_W-1:0]       pc,
    output logic                  retired,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            state
);

    state_t          state_q;
    state_t          state_n;
    cls_t            dec_cls;
    cls_t            cls_q;
    logic            err_q;
    logic            pc_jump;
    logic [CNT_W-1:0] cnt_q;

    assign dec_cls = classify(dec_load, dec_store, dec_jump, dec_imm, dec_alu, instr_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:   if (run && !err_q) state_n = FETCH;
            FETCH:  if (mem.mem_ready) state_n = DECODE;
            DECODE: begin
                case (dec_cls)
                    NOP, JUMP:   state_n = run ? FETCH : IDLE;
                    LOAD, STORE: state_n = MEM;
                    ALU, IMM:    state_n = EXEC;
                    default:     state_n = IDLE;
                endcase
            end
            EXEC:   state_n = WB;
            MEM: begin
                if (mem.mem_ready) begin
                    if (cls_q == STORE) state_n = run ? FETCH : IDLE;
                    else                state_n = WB;
                end
            end
            WB:     state_n = run ? FETCH : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        mem.ir_load      = 1'b0;
        reg_we           = 1'b0;
        wb_sel           = 1'b0;
        retired          = 1'b0;
        pc_jump          = 1'b0;
        case (state_q)
            FETCH: begin
                mem.mem_req = 1'b1;
                mem.ir_load = mem.mem_ready;
            end
            DECODE: begin
                retired = (dec_cls == NOP) || (dec_cls == JUMP);
                pc_jump = (dec_cls == JUMP);
            end
            MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (cls_q == STORE);
                retired          = (cls_q == STORE) && mem.mem_ready;
            end
            WB: begin
                reg_we  = 1'b1;
                wb_sel  = (cls_q == LOAD);
                retired = 1'b1;
            end
            default: ;
        endcase
    end

    // Class is frozen at DECODE so decoder flags may wander during MEM/EXEC/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_q <= NOP;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (state_q == DECODE) begin
                cls_q <= dec_cls;
                if (dec_cls == ILLEGAL) err_q <= 1'b1;
            end
            if (retired) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .advance     (retired),
        .jump        (pc_jump),
        .jump_offset (jump_offset),
        .pc          (pc)
    );

    assign instr_count = cnt_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE);
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: decode table, hand-written corner sequences, and randomized instruction stream vs. a PC/count model.
module tb_cpu_sequencer;

    localparam int K_NOP = 0, K_JUMP = 1, K_LOAD = 2, K_STORE = 3, K_ALU = 4, K_IMM = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        dec_load = 1'b0, dec_store = 1'b0, dec_jump = 1'b0, dec_imm = 1'b0;
    logic [2:0]  dec_alu = 3'd0;
    logic        instr_zero = 1'b0;
    logic [15:0] jump_offset = 16'd0;
    logic        reg_we, wb_sel, retired, busy, err;
    logic [31:0] pc, instr_count;
    logic [2:0]  state;

    cpu_sequencer_if mem_if ();

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .dec_load    (dec_load),
        .dec_store   (dec_store),
        .dec_jump    (dec_jump),
        .dec_imm     (dec_imm),
        .dec_alu     (dec_alu),
        .instr_zero  (instr_zero),
        .jump_offset (jump_offset),
        .mem         (mem_if.master),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc          (pc),
        .retired     (retired),
        .instr_count (instr_count),
        .busy        (busy),
        .err         (err),
        .state       (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] pc_m, cnt_m;

    typedef struct {
        logic [3:0]  f;       // {load, store, jump, imm}
        logic [2:0]  alu;
        logic        zero;
        logic [15:0] off;
        int          lat;     // cycles from first FETCH to retire; 0 = illegal
        logic [31:0] pc_exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, mem_if.ir_load,
                reg_we, wb_sel, retired, busy};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pc_m = 32'd0;
        cnt_m = 32'd0;
        @(negedge clk);
        chk("reset strobes", 64'(strobes()), 64'd0);
        chk("reset pc", 64'(pc), 64'd0);
        chk("reset count", 64'(instr_count), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset state", 64'(state), 64'd0);
    endtask

    // Leaves the DUT in FETCH just after a rising edge.
    task automatic start();
        run = 1'b1;
        do_reset();
        @(posedge clk); #1;
    endtask

    task automatic set_flags(input int k);
        {dec_load, dec_store, dec_jump, dec_imm, dec_alu, instr_zero} = 8'($urandom);
        if (k != K_NOP) begin
            instr_zero = 1'b0;
            {dec_load, dec_store, dec_jump, dec_imm} = 4'b0000;
        end
        case (k)
            K_NOP:   instr_zero = 1'b1;
            K_JUMP:  dec_jump = 1'b1;
            K_LOAD:  dec_load = 1'b1;
            K_STORE: dec_store = 1'b1;
            K_ALU:   dec_alu = 3'($urandom_range(1, 7));
            default: dec_imm = 1'b1;
        endcase
    endtask

    // Drives one instruction starting in FETCH; wf/wm are RAM wait cycles, run drops from cycle drop_at.
    task automatic do_instr(input int k, input logic [15:0] off, input int wf, input int wm, input int drop_at);
        int last;
        if (k == K_NOP || k == K_JUMP) last = wf + 1;
        else if (k == K_STORE)         last = wf + 2 + wm;
        else if (k == K_LOAD)          last = wf + 3 + wm;
        else                           last = wf + 3;
        for (int c = 0; c <= last; c++) begin
            logic f, d, m, w;
            logic [7:0] exp;
            f = (c <= wf);
            d = (c == wf + 1);
            m = (k == K_LOAD || k == K_STORE) && c >= wf + 2 && c <= wf + 2 + wm;
            w = ((k == K_ALU || k == K_IMM) && c == wf + 3) || (k == K_LOAD && c == wf + 3 + wm);
            run = !(drop_at >= 0 && c >= drop_at);
            if (f)      mem_if.mem_ready = (c == wf);
            else if (m) mem_if.mem_ready = (c == wf + 2 + wm);
            else        mem_if.mem_ready = 1'($urandom);
            if (d) begin
                set_flags(k);
                jump_offset = off;
            end else begin
                {dec_load, dec_store, dec_jump, dec_imm, dec_alu, instr_zero} = 8'($urandom);
                jump_offset = 16'($urandom);
            end
            exp = {f || m, m && (k == K_STORE), m, c == wf, w, w && (k == K_LOAD), c == last, 1'b1};
            @(negedge clk);
            chk($sformatf("strobes k%0d c%0d", k, c), 64'(strobes()), 64'(exp));
            @(posedge clk); #1;
        end
        cnt_m = cnt_m + 32'd1;
        pc_m  = pc_m + 32'd1 + ((k == K_JUMP) ? {{16{off[15]}}, off} : 32'd0);
        chk($sformatf("pc after k%0d", k), 64'(pc), 64'(pc_m));
        chk($sformatf("count after k%0d", k), 64'(instr_count), 64'(cnt_m));
        if (!run) chk("idle after run drop", 64'(state), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0000, 3'b010, 1'b0, 16'h0000, 4, 32'd1};
        tbl[1]  = '{4'b0001, 3'b000, 1'b0, 16'h0000, 4, 32'd1};
        tbl[2]  = '{4'b1000, 3'b000, 1'b0, 16'h0000, 4, 32'd1};
        tbl[3]  = '{4'b0100, 3'b000, 1'b0, 16'h0000, 3, 32'd1};
        tbl[4]  = '{4'b0010, 3'b000, 1'b0, 16'h0005, 2, 32'd6};
        tbl[5]  = '{4'b0010, 3'b111, 1'b0, 16'hFFF0, 2, 32'hFFFFFFF1};
        tbl[6]  = '{4'b1010, 3'b000, 1'b1, 16'h0000, 2, 32'd1};
        tbl[7]  = '{4'b1010, 3'b000, 1'b0, 16'h0000, 0, 32'd0};
        tbl[8]  = '{4'b0101, 3'b000, 1'b0, 16'h0000, 0, 32'd0};
        tbl[9]  = '{4'b0000, 3'b000, 1'b0, 16'h0000, 0, 32'd0};
        tbl[10] = '{4'b0011, 3'b001, 1'b0, 16'h0000, 0, 32'd0};
        tbl[11] = '{4'b0001, 3'b110, 1'b0, 16'h0000, 4, 32'd1};

        mem_if.mem_ready = 1'b0;

        // Single instruction from reset, zero-wait RAM, flags held steady.
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            int got;
            v = tbl[i];
            {dec_load, dec_store, dec_jump, dec_imm} = v.f;
            dec_alu = v.alu;
            instr_zero = v.zero;
            jump_offset = v.off;
            mem_if.mem_ready = 1'b1;
            run = 1'b1;
            do_reset();
            got = 0;
            for (int cyc = 1; cyc <= 10 && got == 0; cyc++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (retired) got = cyc;
            end
            if (got != 0) begin
                @(posedge clk); #1;
            end
            chk($sformatf("vec%0d latency", i), 64'(got), 64'(v.lat));
            chk($sformatf("vec%0d pc", i), 64'(pc), 64'(v.pc_exp));
            chk($sformatf("vec%0d count", i), 64'(instr_count), (v.lat != 0) ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d err", i), 64'(err), (v.lat == 0) ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d state", i), 64'(state), (v.lat == 0) ? 64'd0 : 64'd1);
        end

        // Load and store with stalled RAM.
        start();
        do_instr(K_LOAD, 16'h0, 0, 3, -1);
        do_instr(K_STORE, 16'h0, 1, 2, -1);

        // Jump backwards from pc=10, then the next fetch uses the PC address.
        start();
        for (int i = 0; i < 10; i++) do_instr(K_NOP, 16'h0, 0, 0, -1);
        do_instr(K_JUMP, 16'hFFF0, 0, 0, -1);
        chk("jump pc", 64'(pc), 64'hFFFFFFFB);
        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        chk("fetch after jump", 64'({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel}), 64'b100);

        // Reset abandons a stalled MEM access.
        start();
        do_instr(K_NOP, 16'h0, 0, 0, -1);
        do_instr(K_NOP, 16'h0, 0, 0, -1);
        mem_if.mem_ready = 1'b1;
        @(posedge clk); #1;
        {dec_load, dec_store, dec_jump, dec_imm, dec_alu, instr_zero} = {4'b1000, 3'b000, 1'b0};
        @(posedge clk); #1;
        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        chk("stalled mem req", 64'({mem_if.mem_req, mem_if.mem_addr_sel}), 64'b11);
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_if.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst in mem: mem_req", 64'(mem_if.mem_req), 64'd0);
        chk("rst in mem: pc", 64'(pc), 64'd0);
        chk("rst in mem: count", 64'(instr_count), 64'd0);
        chk("rst in mem: state", 64'(state), 64'd0);

        // run dropped mid-ALU, then PC wrap through all-ones.
        start();
        do_instr(K_ALU, 16'h0, 0, 0, 2);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle holds without run", 64'({busy, state}), 64'd0);
        run = 1'b1;
        @(posedge clk); #1;
        do_instr(K_JUMP, 16'hFFFD, 0, 0, -1);
        chk("pc at all-ones", 64'(pc), 64'hFFFFFFFF);
        do_instr(K_NOP, 16'h0, 0, 0, -1);
        chk("pc wraps to zero", 64'(pc), 64'd0);

        // Random instruction stream with random RAM waits and decoder noise.
        start();
        for (int n = 0; n < 60; n++) begin
            do_instr($urandom_range(0, 5), 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
